controle_vai_vem: RTL and testbench
===================================

CONTROLE_VAI_VEM -- requirements
Module: controle_vai_vem

Interface
REQ-001 SHALL have parameter M, default 100: number of positions of the driven up/down counter (0..M-1).
REQ-002 SHALL have parameter N, default 7: position width in bits.
REQ-003 SHALL have parameter T, default 50000: clock cycles per step; T >= 2.
REQ-004 SHALL have port clock  input  1  single system clock, rising edge.
REQ-005 SHALL have port zera_as  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port iniciar  input  1  start command, sampled each clock.
REQ-007 SHALL have port parar  input  1  stop command, sampled each clock.
REQ-008 SHALL have port modo  input  1  0 = sweep (varredura), 1 = seek (busca) to alvo.
REQ-009 SHALL have port centralizar  input  1  seek to M/2-1, sampled in IDLE only.
REQ-010 SHALL have port alvo  input  N  seek target.
REQ-011 SHALL have port Q  input  N  current counter position.
REQ-012 SHALL have port vai  output  1  one-cycle increment pulse to counter.
REQ-013 SHALL have port vem  output  1  one-cycle decrement pulse to counter.
REQ-014 SHALL have port set_pos  output  1  one-cycle load pulse to counter.
REQ-015 SHALL have port D  output  N  load value; constant 0.
REQ-016 SHALL have port sentido  output  1  1 = moving up, 0 = moving down.
REQ-017 SHALL have port pronto  output  1  high while in IDLE.
REQ-018 SHALL have port chegou  output  1  one-cycle pulse when seek target is reached.
REQ-019 SHALL have port db_estado  output  3  current state encoding.

Function
REQ-020 SHALL implement states IDLE=0, PREPARA=1, SUBINDO=2, DESCENDO=3, BUSCA=4, CHEGOU=5; codes 6-7 return to IDLE.
REQ-021 SHALL contain a step divider counting 0..T-1 outside IDLE, cleared on leaving IDLE; tick = divider at T-1.
REQ-022 SHALL register vai, vem, set_pos, chegou: each high for exactly one clock, in the cycle after the deciding state/tick; vai and vem never high together.
REQ-023 IDLE: parar -> stay IDLE; else iniciar & !modo -> PREPARA; else iniciar & modo -> BUSCA with target latched = min(alvo, M-1); else centralizar -> BUSCA with target M/2-1.
REQ-024 PREPARA: issue set_pos (D=0) once; next state SUBINDO; sentido=1.
REQ-025 SUBINDO on tick: Q == M-1 -> issue vem, go DESCENDO, sentido=0; else issue vai.
REQ-026 DESCENDO on tick: Q == 0 -> issue vai, go SUBINDO, sentido=1; else issue vem.
REQ-027 BUSCA on tick: Q < target -> vai, sentido=1; Q > target -> vem, sentido=0; Q == target -> CHEGOU, no step pulse.
REQ-028 CHEGOU: issue chegou once; next state IDLE.
REQ-029 No step pulse outside ticks; target register unchanged outside IDLE.
REQ-030 parar in any non-IDLE state -> IDLE next clock; parar beats a simultaneous tick (no step pulse issued).
REQ-031 iniciar and centralizar SHALL be ignored outside IDLE; iniciar has priority over centralizar.
REQ-032 pronto SHALL be combinational from state (high only in IDLE); sentido holds value in IDLE.

Reset
REQ-033 zera_as high SHALL immediately force state IDLE, divider 0, target 0, vai=vem=set_pos=chegou=0, sentido=1, regardless of clock.
REQ-034 After zera_as falls, SHALL stay IDLE until a valid command; reset mid-sweep or mid-seek SHALL drop any pending pulse.

Verification (bench: M=10, N=4, T=2, ideal counter model on Q)
REQ-035 Reset mid-SUBINDO at Q=4 -> next sample: db_estado=0, pronto=1, vai=vem=0, sentido=1.
REQ-036 iniciar, modo=0 -> set_pos once, Q=0; vai pulses take Q to 9; next tick vem, sentido=0; Q falls to 0, then vai, sentido=1.
REQ-037 Q=2, iniciar, modo=1, alvo=5 -> exactly 3 vai pulses, one chegou pulse, then pronto=1, Q=5.
REQ-038 Q=3, alvo=15 -> target clamps to 9: 6 vai pulses, chegou, Q=9; alvo changed mid-seek has no effect.
REQ-039 Q=8, centralizar -> 4 vem pulses, Q=4, chegou; parar asserted during a seek on a tick cycle -> no pulse, IDLE next clock.
REQ-040 iniciar and parar asserted together in IDLE -> state stays IDLE, no pulses.

Source files
------------

// File: rtl/controle_vai_vem.sv
`default_nettype none
// ============================================================================
// Module      : controle_vai_vem
// Description : Sweep / seek controller for an external up/down position
//               counter. Issues one-clock vai/vem/set_pos pulses on a fixed
//               step cadence, either sweeping 0..M-1 back and forth or
//               seeking a latched target and flagging arrival with chegou.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_vai_vem #(
  parameter int M = 100,
  parameter int N = 7,
  parameter int T = 50000
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         iniciar,
  input  logic         parar,
  input  logic         modo,
  input  logic         centralizar,
  input  logic [N-1:0] alvo,
  input  logic [N-1:0] Q,
  output logic         vai,
  output logic         vem,
  output logic         set_pos,
  output logic [N-1:0] D,
  output logic         sentido,
  output logic         pronto,
  output logic         chegou,
  output logic [2:0]   db_estado
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREPARA  = 3'd1,
    SUBINDO  = 3'd2,
    DESCENDO = 3'd3,
    BUSCA    = 3'd4,
    CHEGOU   = 3'd5
  } estado_t;

  localparam int           c_div_w   = (T > 2) ? $clog2(T) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(T - 1);
  localparam logic [N-1:0] c_pos_max = N'(M - 1);
  localparam logic [N-1:0] c_centro  = N'(M / 2 - 1);

  estado_t              r_estado;
  estado_t              w_prox;
  logic [c_div_w-1:0]   r_div;
  logic                 w_tick;
  logic [N-1:0]         r_alvo;
  logic [N-1:0]         w_alvo;
  logic                 r_sentido;
  logic                 w_sentido;
  logic                 r_vai, r_vem, r_set_pos, r_chegou;
  logic                 w_vai, w_vem, w_set_pos, w_chegou;

  // The step cadence only runs while the controller is busy.
  assign w_tick = (r_estado != IDLE) && (r_div == c_div_max);

  // State, divider, target, direction and pulse registers.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      r_estado  <= IDLE;
      r_div     <= '0;
      r_alvo    <= '0;
      r_sentido <= 1'b1;
      r_vai     <= 1'b0;
      r_vem     <= 1'b0;
      r_set_pos <= 1'b0;
      r_chegou  <= 1'b0;
    end else begin
      r_estado  <= w_prox;
      r_alvo    <= w_alvo;
      r_sentido <= w_sentido;
      r_vai     <= w_vai;
      r_vem     <= w_vem;
      r_set_pos <= w_set_pos;
      r_chegou  <= w_chegou;
      if (r_estado == IDLE || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + c_div_w'(1);
      end
    end
  end

  // Next state, target latch, direction and step decisions.
  always_comb begin
    w_prox    = r_estado;
    w_alvo    = r_alvo;
    w_sentido = r_sentido;
    w_vai     = 1'b0;
    w_vem     = 1'b0;
    w_set_pos = 1'b0;
    w_chegou  = 1'b0;
    case (r_estado)
      IDLE: begin
        if (parar) begin
          w_prox = IDLE;
        end else if (iniciar && !modo) begin
          w_prox = PREPARA;
        end else if (iniciar && modo) begin
          w_prox = BUSCA;
          w_alvo = (alvo > c_pos_max) ? c_pos_max : alvo;
        end else if (centralizar) begin
          w_prox = BUSCA;
          w_alvo = c_centro;
        end
      end
      PREPARA: begin
        if (parar) begin
          w_prox = IDLE;
        end else begin
          w_set_pos = 1'b1;
          w_sentido = 1'b1;
          w_prox    = SUBINDO;
        end
      end
      SUBINDO: begin
        if (parar) begin
          w_prox = IDLE;
        end else if (w_tick) begin
          if (Q == c_pos_max) begin
            w_vem     = 1'b1;
            w_sentido = 1'b0;
            w_prox    = DESCENDO;
          end else begin
            w_vai = 1'b1;
          end
        end
      end
      DESCENDO: begin
        if (parar) begin
          w_prox = IDLE;
        end else if (w_tick) begin
          if (Q == '0) begin
            w_vai     = 1'b1;
            w_sentido = 1'b1;
            w_prox    = SUBINDO;
          end else begin
            w_vem = 1'b1;
          end
        end
      end
      BUSCA: begin
        if (parar) begin
          w_prox = IDLE;
        end else if (w_tick) begin
          if (Q < r_alvo) begin
            w_vai     = 1'b1;
            w_sentido = 1'b1;
          end else if (Q > r_alvo) begin
            w_vem     = 1'b1;
            w_sentido = 1'b0;
          end else begin
            w_prox = CHEGOU;
          end
        end
      end
      CHEGOU: begin
        w_chegou = 1'b1;
        w_prox   = IDLE;
      end
      default: begin
        w_prox = IDLE;
      end
    endcase
  end

  assign vai       = r_vai;
  assign vem       = r_vem;
  assign set_pos   = r_set_pos;
  assign chegou    = r_chegou;
  assign sentido   = r_sentido;
  assign D         = '0;
  assign pronto    = (r_estado == IDLE);
  assign db_estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controle_vai_vem.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_vai_vem
// Description : Directed self-checking bench for controle_vai_vem with an
//               ideal mod-10 up/down counter closing the loop on Q.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_vai_vem;

  localparam int M = 10;
  localparam int N = 4;
  localparam int T = 2;

  logic         clock = 1'b0;
  logic         zera_as;
  logic         iniciar, parar, modo, centralizar;
  logic [N-1:0] alvo;
  logic [N-1:0] q_model;
  logic         vai, vem, set_pos, sentido, pronto, chegou;
  logic [N-1:0] D;
  logic [2:0]   db_estado;

  logic         tb_load = 1'b0;
  logic [N-1:0] tb_val  = '0;

  int n_vec = 0;
  int n_err = 0;
  int n_vai, n_vem, n_set, n_chg, n_both;

  controle_vai_vem #(.M(M), .N(N), .T(T)) dut (
    .clock       (clock),
    .zera_as     (zera_as),
    .iniciar     (iniciar),
    .parar       (parar),
    .modo        (modo),
    .centralizar (centralizar),
    .alvo        (alvo),
    .Q           (q_model),
    .vai         (vai),
    .vem         (vem),
    .set_pos     (set_pos),
    .D           (D),
    .sentido     (sentido),
    .pronto      (pronto),
    .chegou      (chegou),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // Ideal position counter driven by the controller pulses.
  always @(posedge clock) begin
    if (tb_load)      q_model <= tb_val;
    else if (set_pos) q_model <= D;
    else if (vai)     q_model <= (q_model == N'(M - 1)) ? '0 : q_model + 1'b1;
    else if (vem)     q_model <= (q_model == '0) ? N'(M - 1) : q_model - 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_q(input int v);
    @(negedge clock);
    tb_load = 1'b1;
    tb_val  = N'(v);
    @(negedge clock);
    tb_load = 1'b0;
  endtask

  task automatic clear_counts();
    n_vai = 0; n_vem = 0; n_set = 0; n_chg = 0; n_both = 0;
  endtask

  task automatic count_pulses(input int ciclos);
    for (int i = 0; i < ciclos; i++) begin
      @(negedge clock);
      if (vai) n_vai++;
      if (vem) n_vem++;
      if (set_pos) n_set++;
      if (chegou) n_chg++;
      if (vai && vem) n_both++;
    end
  endtask

  task automatic comando(input logic ini, input logic cen, input logic par);
    @(negedge clock);
    iniciar = ini; centralizar = cen; parar = par;
    @(negedge clock);
    iniciar = 1'b0; centralizar = 1'b0; parar = 1'b0;
  endtask

  initial begin
    int fase;
    bit achou;

    zera_as = 1'b1; iniciar = 1'b0; parar = 1'b0; modo = 1'b0;
    centralizar = 1'b0; alvo = '0;
    #1;
    check("rst_estado", db_estado, 0);
    check("rst_pronto", pronto, 1);
    check("rst_pulsos", {vai, vem, set_pos, chegou}, 0);
    check("rst_sentido", sentido, 1);
    check("rst_D", D, 0);
    @(negedge clock);
    zera_as = 1'b0;
    set_q(4);

    // Start a sweep, then reset asynchronously while climbing through Q=4.
    modo = 1'b0;
    comando(1'b1, 1'b0, 1'b0);
    achou = 1'b0;
    for (int i = 0; i < 60 && !achou; i++) begin
      @(negedge clock);
      if (q_model == 4'd4 && db_estado == 3'd2) achou = 1'b1;
    end
    check("rst_mid_reached", achou, 1);
    zera_as = 1'b1;
    #1;
    check("rst_mid_estado", db_estado, 0);
    check("rst_mid_pronto", pronto, 1);
    check("rst_mid_vaivem", {vai, vem}, 0);
    check("rst_mid_sentido", sentido, 1);
    @(negedge clock);
    zera_as = 1'b0;
    count_pulses(3);
    check("rst_idle_stay", db_estado, 0);

    // Full sweep: 0 up to 9, reverse, down to 0, reverse again.
    clear_counts();
    comando(1'b1, 1'b0, 1'b0);
    fase = 0;
    for (int i = 0; i < 80 && fase < 2; i++) begin
      @(negedge clock);
      if (set_pos) n_set++;
      if (vai && vem) n_both++;
      if (fase == 0) begin
        if (vai) n_vai++;
        if (vem) begin
          check("sweep_top_q", q_model, 9);
          check("sweep_sentido_dn", sentido, 0);
          check("sweep_up_steps", n_vai, 9);
          fase  = 1;
          n_vem = 1;
        end
      end else begin
        if (vem) n_vem++;
        if (vai) begin
          check("sweep_bot_q", q_model, 0);
          check("sweep_sentido_up", sentido, 1);
          check("sweep_dn_steps", n_vem, 9);
          fase = 2;
        end
      end
    end
    check("sweep_done", fase, 2);
    check("sweep_set_pos", n_set, 1);
    check("sweep_vai_vem_excl", n_both, 0);
    comando(1'b0, 1'b0, 1'b1);
    check("sweep_parar", db_estado, 0);

    // Seek Q=2 -> 5.
    set_q(2);
    modo = 1'b1; alvo = 4'd5;
    clear_counts();
    comando(1'b1, 1'b0, 1'b0);
    count_pulses(30);
    check("seek5_vai", n_vai, 3);
    check("seek5_vem", n_vem, 0);
    check("seek5_chegou", n_chg, 1);
    check("seek5_q", q_model, 5);
    check("seek5_pronto", pronto, 1);

    // Seek with an out-of-range target; alvo changes mid-seek are ignored.
    set_q(3);
    alvo = 4'd15;
    clear_counts();
    comando(1'b1, 1'b0, 1'b0);
    count_pulses(4);
    alvo = 4'd0;
    count_pulses(36);
    check("clamp_vai", n_vai, 6);
    check("clamp_vem", n_vem, 0);
    check("clamp_chegou", n_chg, 1);
    check("clamp_q", q_model, 9);

    // Centre seek from Q=8 to M/2-1 = 4.
    set_q(8);
    modo = 1'b0;
    clear_counts();
    comando(1'b0, 1'b1, 1'b0);
    count_pulses(30);
    check("centro_vem", n_vem, 4);
    check("centro_vai", n_vai, 0);
    check("centro_chegou", n_chg, 1);
    check("centro_q", q_model, 4);
    check("centro_sentido_hold", sentido, 0);
    check("centro_pronto", pronto, 1);

    // parar on the first tick of a seek beats the step.
    set_q(0);
    modo = 1'b1; alvo = 4'd9;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    parar = 1'b1;
    @(negedge clock);
    parar = 1'b0;
    check("stop_tick_estado", db_estado, 0);
    check("stop_tick_vai", vai, 0);
    clear_counts();
    count_pulses(6);
    check("stop_tick_nopulse", n_vai + n_vem + n_chg, 0);
    check("stop_tick_q", q_model, 0);

    // iniciar together with parar in IDLE does nothing.
    modo = 1'b0;
    clear_counts();
    comando(1'b1, 1'b0, 1'b1);
    check("ini_par_estado", db_estado, 0);
    count_pulses(6);
    check("ini_par_nopulse", n_vai + n_vem + n_set + n_chg, 0);
    check("ini_par_pronto", pronto, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
